// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// A single IDLE -> EXEC -> RESP sequence serves one operation at a time.
module alu_arbiter #(
    parameter int n = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ0_VALID,
    output logic         REQ0_READY,
    input  logic [n-1:0] REQ0_A,
    input  logic [n-1:0] REQ0_B,
    input  logic [3:0]   REQ0_FUN,
    input  logic         REQ1_VALID,
    output logic         REQ1_READY,
    input  logic [n-1:0] REQ1_A,
    input  logic [n-1:0] REQ1_B,
    input  logic [3:0]   REQ1_FUN,
    output logic         RSP0_VALID,
    input  logic         RSP0_READY,
    output logic [n-1:0] RSP0_RESULT,
    output logic         RSP0_ZERO,
    output logic         RSP1_VALID,
    input  logic         RSP1_READY,
    output logic [n-1:0] RSP1_RESULT,
    output logic         RSP1_ZERO,
    output logic [n-1:0] ALU_A,
    output logic [n-1:0] ALU_B,
    output logic [3:0]   ALU_FUN,
    input  logic [n-1:0] ALU_RESULT,
    input  logic         ALU_ZERO,
    output logic         BUSY
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           gnt_q, gnt_d;
    logic [n-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]     fun_q, fun_d;
    logic           zero_q, zero_d;

    logic           grant_id;
    logic           accept;
    logic           rsp_done;

    always_comb begin
        // Contention goes to whoever was not served last; otherwise the lone requester wins.
        grant_id = (REQ0_VALID && REQ1_VALID) ? ~last_q : REQ1_VALID;
        accept   = RST_N && (state_q == IDLE) && (REQ0_VALID || REQ1_VALID);
        rsp_done = (state_q == RESP) && (gnt_q ? RSP1_READY : RSP0_READY);

        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        res_d   = res_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: if (accept) begin
                gnt_d   = grant_id;
                a_d     = grant_id ? REQ1_A   : REQ0_A;
                b_d     = grant_id ? REQ1_B   : REQ0_B;
                fun_d   = grant_id ? REQ1_FUN : REQ0_FUN;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = ALU_RESULT;
                zero_d  = ALU_ZERO;
                state_d = RESP;
            end
            RESP: if (rsp_done) begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign REQ0_READY  = accept && !grant_id;
    assign REQ1_READY  = accept && grant_id;

    assign ALU_A       = a_q;
    assign ALU_B       = b_q;
    assign ALU_FUN     = fun_q;
    assign BUSY        = (state_q != IDLE);

    // The idle requester's response lanes stay at zero rather than echoing stale data.
    assign RSP0_VALID  = (state_q == RESP) && !gnt_q;
    assign RSP1_VALID  = (state_q == RESP) && gnt_q;
    assign RSP0_RESULT = RSP0_VALID ? res_q : '0;
    assign RSP1_RESULT = RSP1_VALID ? res_q : '0;
    assign RSP0_ZERO   = RSP0_VALID && zero_q;
    assign RSP1_ZERO   = RSP1_VALID && zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter; the bench also plays the shared ALU.
module tb_alu_arbiter;
    localparam int N = 32;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
    logic [N-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic [3:0]   REQ0_FUN, REQ1_FUN;
    logic         RSP0_VALID, RSP0_READY, RSP0_ZERO;
    logic         RSP1_VALID, RSP1_READY, RSP1_ZERO;
    logic [N-1:0] RSP0_RESULT, RSP1_RESULT;
    logic [N-1:0] ALU_A, ALU_B, ALU_RESULT;
    logic [3:0]   ALU_FUN;
    logic         ALU_ZERO, BUSY;

    always #5 CLK = ~CLK;

    alu_arbiter #(.n(N)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
        .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP0_RESULT(RSP0_RESULT), .RSP0_ZERO(RSP0_ZERO),
        .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY), .RSP1_RESULT(RSP1_RESULT), .RSP1_ZERO(RSP1_ZERO),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO),
        .BUSY(BUSY)
    );

    function automatic logic [N-1:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] f);
        case (f)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b0001: return a << b[4:0];
            4'b1101: return N'($signed(a) >>> b[4:0]);
            4'b0010: return N'($signed(a) < $signed(b));
            4'b0011: return N'(a < b);
            4'b1001: return b;
            default: return '0;
        endcase
    endfunction

    assign ALU_RESULT = alu_model(ALU_A, ALU_B, ALU_FUN);
    assign ALU_ZERO   = (ALU_RESULT == '0);

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 executing, 2 responding
    int           m_phase;
    bit           m_last, m_gnt;
    logic [N-1:0] m_a, m_b;
    logic [3:0]   m_fun;
    logic [N:0]   exp_q0[$], exp_q1[$];
    int           ops;
    bit           acc0, acc1;
    int           gseq[$];

    logic [3:0] funs [11] = '{4'b0000, 4'b1000, 4'b0110, 4'b0111, 4'b0100, 4'b0101,
                              4'b0001, 4'b1101, 4'b0010, 4'b0011, 4'b1001};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_last = 1'b1; m_gnt = 1'b0;
        m_a = '0; m_b = '0; m_fun = '0;
        exp_q0.delete(); exp_q1.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy0"}, 64'(REQ0_READY), 0);
        chk({tag, "_rdy1"}, 64'(REQ1_READY), 0);
        chk({tag, "_rsp0v"}, 64'(RSP0_VALID), 0);
        chk({tag, "_rsp1v"}, 64'(RSP1_VALID), 0);
        chk({tag, "_rsp0r"}, 64'({RSP0_RESULT, RSP0_ZERO}), 0);
        chk({tag, "_rsp1r"}, 64'({RSP1_RESULT, RSP1_ZERO}), 0);
        chk({tag, "_busy"}, 64'(BUSY), 0);
        chk({tag, "_alu"}, 64'({ALU_A, ALU_B, ALU_FUN} != '0), 0);
    endtask

    // One clock: check outputs against the model mid-cycle, advance the model, return at posedge+1.
    task automatic cycle();
        bit e0, e1;
        logic [N:0] front;
        @(negedge CLK);
        if (!RST_N) begin
            model_reset();
            chk_all_zero("rst");
        end else begin
            e0 = (m_phase == 0) && REQ0_VALID && (!REQ1_VALID || m_last);
            e1 = (m_phase == 0) && REQ1_VALID && (!REQ0_VALID || !m_last);
            chk("rdy0", 64'(REQ0_READY), 64'(e0));
            chk("rdy1", 64'(REQ1_READY), 64'(e1));
            chk("rdy_excl", 64'(REQ0_READY && REQ1_READY), 0);
            chk("busy", 64'(BUSY), 64'(m_phase != 0));
            chk("rsp0v", 64'(RSP0_VALID), 64'(m_phase == 2 && !m_gnt));
            chk("rsp1v", 64'(RSP1_VALID), 64'(m_phase == 2 && m_gnt));
            if (m_phase != 0) chk("alu_ops", 64'({ALU_A, ALU_B, ALU_FUN}), 64'({m_a, m_b, m_fun}));
            if (m_phase == 2) begin
                front = m_gnt ? exp_q1[0] : exp_q0[0];
                if (m_gnt) begin
                    chk("rsp1_data", 64'({RSP1_RESULT, RSP1_ZERO}), 64'(front));
                    chk("rsp0_idle", 64'({RSP0_RESULT, RSP0_ZERO}), 0);
                end else begin
                    chk("rsp0_data", 64'({RSP0_RESULT, RSP0_ZERO}), 64'(front));
                    chk("rsp1_idle", 64'({RSP1_RESULT, RSP1_ZERO}), 0);
                end
            end
            if (REQ0_READY) gseq.push_back(0);
            if (REQ1_READY) gseq.push_back(1);
            case (m_phase)
                0: if (e0 || e1) begin
                    m_gnt = e1;
                    m_a   = e1 ? REQ1_A : REQ0_A;
                    m_b   = e1 ? REQ1_B : REQ0_B;
                    m_fun = e1 ? REQ1_FUN : REQ0_FUN;
                    front = {alu_model(m_a, m_b, m_fun), alu_model(m_a, m_b, m_fun) == '0};
                    if (e1) begin exp_q1.push_back(front); acc1 = 1; end
                    else begin exp_q0.push_back(front); acc0 = 1; end
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (m_gnt ? RSP1_READY : RSP0_READY) begin
                    if (m_gnt) void'(exp_q1.pop_front()); else void'(exp_q0.pop_front());
                    m_last = m_gnt; m_phase = 0; ops++;
                end
            endcase
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        int cyc;
        RST_N = 0;
        REQ0_VALID = 0; REQ0_A = '0; REQ0_B = '0; REQ0_FUN = '0;
        REQ1_VALID = 0; REQ1_A = '0; REQ1_B = '0; REQ1_FUN = '0;
        RSP0_READY = 0; RSP1_READY = 0;
        model_reset(); ops = 0;
        cycle(); cycle();

        // Single op right after release: first grant in the first cycle out of reset
        RST_N = 1;
        REQ0_VALID = 1; REQ0_A = 5; REQ0_B = 3; REQ0_FUN = 4'b0000; RSP0_READY = 1;
        cycle();
        REQ0_VALID = 0;
        chk("single_busy", 64'(BUSY), 1);
        chk("single_alu_a", 64'(ALU_A), 5);
        chk("single_no_rsp", 64'(RSP0_VALID), 0);
        cycle();
        chk("single_rsp_v", 64'(RSP0_VALID), 1);
        chk("single_result", 64'(RSP0_RESULT), 8);
        chk("single_zero", 64'(RSP0_ZERO), 0);
        cycle();
        chk("single_done", 64'(BUSY), 0);

        // Alternation from reset with both requesting continuously
        RST_N = 0; cycle(); RST_N = 1;
        gseq.delete();
        REQ0_VALID = 1; REQ0_A = 10; REQ0_B = 4; REQ0_FUN = 4'b1000;
        REQ1_VALID = 1; REQ1_A = 3;  REQ1_B = 12; REQ1_FUN = 4'b0110;
        RSP1_READY = 1;
        cyc = 0;
        while (gseq.size() < 4 && cyc < 40) begin cycle(); cyc++; end
        chk("alt_count", 64'(gseq.size()), 4);
        for (int k = 0; k < 4 && k < gseq.size(); k++) chk($sformatf("alt_grant%0d", k), 64'(gseq[k]), 64'(k % 2));
        REQ0_VALID = 0; REQ1_VALID = 0;
        while (m_phase != 0 && cyc < 60) begin cycle(); cyc++; end

        // Backpressure on requester 1 while requester 0 waits
        REQ1_VALID = 1; REQ1_A = 7; REQ1_B = 7; REQ1_FUN = 4'b1000; RSP1_READY = 0;
        cycle();
        REQ1_VALID = 0; REQ0_VALID = 1; REQ0_A = 9; REQ0_B = 2; REQ0_FUN = 4'b0001;
        cycle();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp1v", 64'(RSP1_VALID), 1);
            chk("bp_result", 64'(RSP1_RESULT), 0);
            chk("bp_zero", 64'(RSP1_ZERO), 1);
            chk("bp_rdy0", 64'(REQ0_READY), 0);
            cycle();
        end
        RSP1_READY = 1;
        cycle();
        chk("bp_rdy0_after", 64'(REQ0_READY), 1);
        cycle();
        REQ0_VALID = 0;
        cycle(); cycle();

        // Asynchronous reset in the middle of an operation
        REQ1_VALID = 1; REQ1_A = 1; REQ1_B = 1; REQ1_FUN = 4'b0000;
        cycle();
        REQ1_VALID = 0;
        chk("mid_busy", 64'(BUSY), 1);
        RST_N = 0;
        #1;
        chk_all_zero("async_rst");
        cycle();
        RST_N = 1;
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_rsp", 64'(RSP0_VALID || RSP1_VALID), 0);
            cycle();
        end
        REQ0_VALID = 1; REQ1_VALID = 1;
        #1;
        chk("post_rst_g0", 64'(REQ0_READY), 1);
        chk("post_rst_g1", 64'(REQ1_READY), 0);
        cycle();
        REQ0_VALID = 0; REQ1_VALID = 0;
        cycle(); cycle(); cycle();

        // Randomized traffic against the model
        ops = 0; cyc = 0; acc0 = 0; acc1 = 0;
        while (ops < 10000 && cyc < 90000) begin
            if (!REQ0_VALID || acc0) begin
                REQ0_VALID = ($urandom % 4) != 0;
                REQ0_A = $urandom; REQ0_FUN = funs[$urandom % 11];
                REQ0_B = ($urandom % 4 == 0) ? REQ0_A : N'($urandom);
            end
            if (!REQ1_VALID || acc1) begin
                REQ1_VALID = ($urandom % 4) != 0;
                REQ1_A = $urandom; REQ1_FUN = funs[$urandom % 11];
                REQ1_B = ($urandom % 4 == 0) ? REQ1_A : N'($urandom);
            end
            acc0 = 0; acc1 = 0;
            RSP0_READY = ($urandom % 8) != 0;
            RSP1_READY = ($urandom % 8) != 0;
            cycle();
            cyc++;
        end
        chk("rand_ops_done", 64'(ops >= 10000), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
